branch_controller: RTL and testbench

BRANCH_CONTROLLER -- requirements
Module: branch_controller

---
 rtl/mips_core_pkg.sv | 18 +
 rtl/branch_controller_sat_counter2.sv | 21 ++
 rtl/branch_controller.sv | 103 ++++++++++
 tb/tb_branch_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core definitions: address width, BHT counter encoding and reset value.
// The branch controller's optional statistics outputs are enabled with BRANCH_STATS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } bht_cnt_e;

    localparam bht_cnt_e BHT_INIT = CNT_WNT;

endpackage

// File: rtl/branch_controller_sat_counter2.sv
// Combinational next state of one 2-bit saturating branch-history counter.
module sat_counter2
    import mips_core::*;
(
    input  bht_cnt_e cnt_i,
    input  logic     taken_i,
    output bht_cnt_e cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        case (cnt_i)
            CNT_SNT: cnt_o = taken_i ? CNT_WNT : CNT_SNT;
            CNT_WNT: cnt_o = taken_i ? CNT_WT  : CNT_SNT;
            CNT_WT:  cnt_o = taken_i ? CNT_ST  : CNT_WNT;
            CNT_ST:  cnt_o = taken_i ? CNT_ST  : CNT_WT;
            default: cnt_o = cnt_i;
        endcase
    end

endmodule

// File: rtl/branch_controller.sv
// Bimodal branch predictor with EX-stage mispredict detection and fetch redirect.
// Optional outputs o_branch_count / o_mispredict_count exist only with BRANCH_STATS_EN.
module branch_controller
    import mips_core::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dec_valid,
    input  logic                   dec_is_jump,
    input  logic [`ADDR_WIDTH-1:0] dec_pc,
    input  logic [`ADDR_WIDTH-1:0] dec_target,
    input  logic [`ADDR_WIDTH-1:0] dec_fallthrough,
    output logic                   dec_prediction,
    output logic [`ADDR_WIDTH-1:0] dec_recovery_target,
    input  logic                   ex_valid,
    input  logic [`ADDR_WIDTH-1:0] ex_pc,
    input  logic                   ex_prediction,
    input  logic                   ex_outcome,
    input  logic [`ADDR_WIDTH-1:0] ex_recovery_target,
    output logic                   o_flush,
    output logic [`ADDR_WIDTH-1:0] o_redirect_target
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]            o_branch_count,
    output logic [31:0]            o_mispredict_count
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    bht_cnt_e               bht_q [ENTRIES];
    logic [INDEX_BITS-1:0]  dec_idx;
    logic [INDEX_BITS-1:0]  ex_idx;
    logic [1:0]             dec_cnt;
    bht_cnt_e               ex_cnt;
    bht_cnt_e               ex_cnt_d;
    logic                   mispredict;
    logic                   unused_pc_bits;

    assign dec_idx        = dec_pc[INDEX_BITS+1:2];
    assign ex_idx         = ex_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{dec_pc, ex_pc};

    // Single update path: only the resolving branch's entry changes per cycle.
    assign ex_cnt = bht_q[ex_idx];

    sat_counter2 u_sat_counter2 (
        .cnt_i   (ex_cnt),
        .taken_i (ex_outcome),
        .cnt_o   (ex_cnt_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= BHT_INIT;
            end
        end else if (ex_valid) begin
            bht_q[ex_idx] <= ex_cnt_d;
        end
    end

    // Decode reads the registered table, so a same-cycle update is not visible yet.
    assign dec_cnt = 2'(bht_q[dec_idx]);

    always_comb begin
        dec_prediction = 1'b0;
        if (!rst && dec_valid) begin
            dec_prediction = dec_is_jump | dec_cnt[1];
        end
    end

    assign dec_recovery_target = dec_prediction ? dec_fallthrough : dec_target;

    assign mispredict        = ex_valid & (ex_prediction != ex_outcome);
    assign o_flush           = ~rst & mispredict;
    assign o_redirect_target = o_flush ? ex_recovery_target : '0;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (ex_valid && (branch_count_q != '1)) begin
                branch_count_q <= branch_count_q + 32'd1;
            end
            if (o_flush && (mispredict_count_q != '1)) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end
        end
    end

    assign o_branch_count     = branch_count_q;
    assign o_mispredict_count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_controller.sv
// Bench for branch_controller: directed vector table plus randomized traffic
// compared against a counter-array model of the predictor.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_controller;

    localparam int AW = `ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid;
    logic          dec_is_jump;
    logic [AW-1:0] dec_pc;
    logic [AW-1:0] dec_target;
    logic [AW-1:0] dec_fallthrough;
    logic          dec_prediction;
    logic [AW-1:0] dec_recovery_target;
    logic          ex_valid;
    logic [AW-1:0] ex_pc;
    logic          ex_prediction;
    logic          ex_outcome;
    logic [AW-1:0] ex_recovery_target;
    logic          o_flush;
    logic [AW-1:0] o_redirect_target;
`ifdef BRANCH_STATS_EN
    logic [31:0]   o_branch_count;
    logic [31:0]   o_mispredict_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    branch_controller #(.INDEX_BITS(6)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dec_valid           (dec_valid),
        .dec_is_jump         (dec_is_jump),
        .dec_pc              (dec_pc),
        .dec_target          (dec_target),
        .dec_fallthrough     (dec_fallthrough),
        .dec_prediction      (dec_prediction),
        .dec_recovery_target (dec_recovery_target),
        .ex_valid            (ex_valid),
        .ex_pc               (ex_pc),
        .ex_prediction       (ex_prediction),
        .ex_outcome          (ex_outcome),
        .ex_recovery_target  (ex_recovery_target),
        .o_flush             (o_flush),
        .o_redirect_target   (o_redirect_target)
`ifdef BRANCH_STATS_EN
        ,
        .o_branch_count      (o_branch_count),
        .o_mispredict_count  (o_mispredict_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          dv;
        logic          jmp;
        logic [AW-1:0] dpc;
        logic          ev;
        logic [AW-1:0] epc;
        logic          epred;
        logic          eout;
        logic [AW-1:0] erec;
        logic          exp_pred;
        logic          exp_flush;
        logic [AW-1:0] exp_redir;
    } vec_t;

    vec_t vecs [16];

    // Reference model: one integer 0..3 per table entry.
    int model_bht [64];

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic dv, input logic jmp, input logic [AW-1:0] dpc,
                         input logic ev, input logic [AW-1:0] epc, input logic epred,
                         input logic eout, input logic [AW-1:0] erec);
        rst                = r;
        dec_valid          = dv;
        dec_is_jump        = jmp;
        dec_pc             = dpc;
        dec_target         = dpc + 32'h1000;
        dec_fallthrough    = dpc + 32'd4;
        ex_valid           = ev;
        ex_pc              = epc;
        ex_prediction      = epred;
        ex_outcome         = eout;
        ex_recovery_target = erec;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_bht[i] = 1;
    endtask

    task automatic model_clock(input logic r, input logic ev, input logic [AW-1:0] epc, input logic eout);
        int idx;
        idx = int'((epc / 4) % 64);
        if (r) model_reset();
        else if (ev) begin
            if (eout) model_bht[idx] = (model_bht[idx] == 3) ? 3 : model_bht[idx] + 1;
            else      model_bht[idx] = (model_bht[idx] == 0) ? 0 : model_bht[idx] - 1;
        end
    endtask

    initial begin
        logic          r, dv, jmp, ev, ep, eo;
        logic [AW-1:0] dpc, epc, erec;
        logic          exp_pred, exp_flush;
        logic [AW-1:0] exp_rec, exp_redir;

        //           rst  dv   jmp  dpc     ev   epc     epr  eout erec     pred flush redir
        vecs[0]  = '{1'b1,1'b1,1'b0,32'h40, 1'b1,32'h40, 1'b0,1'b1,32'h100, 1'b0,1'b0,32'h0};
        vecs[1]  = '{1'b0,1'b1,1'b0,32'h40, 1'b0,32'h0,  1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0};
        vecs[2]  = '{1'b0,1'b1,1'b0,32'h40, 1'b1,32'h40, 1'b0,1'b1,32'h44,  1'b0,1'b1,32'h44};
        vecs[3]  = '{1'b0,1'b1,1'b0,32'h40, 1'b1,32'h40, 1'b1,1'b1,32'h44,  1'b1,1'b0,32'h0};
        vecs[4]  = '{1'b0,1'b1,1'b0,32'h40, 1'b1,32'hC0, 1'b0,1'b1,32'h100, 1'b1,1'b1,32'h100};
        vecs[5]  = '{1'b0,1'b1,1'b0,32'h80, 1'b1,32'h80, 1'b0,1'b1,32'h200, 1'b0,1'b1,32'h200};
        vecs[6]  = '{1'b0,1'b1,1'b0,32'h80, 1'b1,32'h40, 1'b1,1'b1,32'h44,  1'b1,1'b0,32'h0};
        vecs[7]  = '{1'b0,1'b1,1'b0,32'h40, 1'b1,32'h10, 1'b0,1'b0,32'h14,  1'b1,1'b0,32'h0};
        vecs[8]  = '{1'b0,1'b1,1'b0,32'h10, 1'b1,32'h10, 1'b1,1'b0,32'h300, 1'b0,1'b1,32'h300};
        vecs[9]  = '{1'b0,1'b1,1'b1,32'h10, 1'b0,32'h0,  1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0};
        vecs[10] = '{1'b0,1'b0,1'b0,32'h40, 1'b0,32'h0,  1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0};
        vecs[11] = '{1'b1,1'b1,1'b0,32'h40, 1'b1,32'h40, 1'b0,1'b1,32'h500, 1'b0,1'b0,32'h0};
        vecs[12] = '{1'b0,1'b1,1'b0,32'h40, 1'b0,32'h0,  1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0};
        vecs[13] = '{1'b0,1'b1,1'b0,32'h40, 1'b1,32'h140,1'b0,1'b1,32'h400, 1'b0,1'b1,32'h400};
        vecs[14] = '{1'b0,1'b1,1'b0,32'h40, 1'b0,32'h0,  1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0};
        vecs[15] = '{1'b0,1'b1,1'b1,32'h10, 1'b1,32'h10, 1'b1,1'b1,32'h14,  1'b1,1'b0,32'h0};

        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 16; i++) begin
            #1;
            drive(vecs[i].rst, vecs[i].dv, vecs[i].jmp, vecs[i].dpc, vecs[i].ev, vecs[i].epc,
                  vecs[i].epred, vecs[i].eout, vecs[i].erec);
            @(negedge clk);
            exp_rec = vecs[i].exp_pred ? (vecs[i].dpc + 32'd4) : (vecs[i].dpc + 32'h1000);
            check($sformatf("vec%0d_pred", i), AW'(dec_prediction), AW'(vecs[i].exp_pred));
            check($sformatf("vec%0d_rec", i), dec_recovery_target, exp_rec);
            check($sformatf("vec%0d_flush", i), AW'(o_flush), AW'(vecs[i].exp_flush));
            check($sformatf("vec%0d_redir", i), o_redirect_target, vecs[i].exp_redir);
`ifdef BRANCH_STATS_EN
            if (i == 12) begin
                check("stats_branch_after_rst", o_branch_count, '0);
                check("stats_mispredict_after_rst", o_mispredict_count, '0);
            end
`endif
            @(posedge clk);
        end

        // Randomized traffic against the model, starting from a clean reset.
        #1;
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
        @(posedge clk);
        model_reset();

        for (int c = 0; c < 400; c++) begin
            #1;
            r    = ($urandom_range(0, 59) == 0);
            dv   = $urandom_range(0, 1);
            jmp  = ($urandom_range(0, 4) == 0);
            dpc  = AW'($urandom_range(0, 255)) << 2;
            ev   = ($urandom_range(0, 3) != 0);
            epc  = AW'($urandom_range(0, 255)) << 2;
            ep   = $urandom_range(0, 1);
            eo   = ($urandom_range(0, 2) != 0);
            erec = AW'($urandom);
            drive(r, dv, jmp, dpc, ev, epc, ep, eo, erec);

            exp_pred  = !r && dv && (jmp || model_bht[(dpc / 4) % 64] >= 2);
            exp_rec   = exp_pred ? (dpc + 32'd4) : (dpc + 32'h1000);
            exp_flush = !r && ev && (ep != eo);
            exp_redir = exp_flush ? erec : '0;

            @(negedge clk);
            check("rnd_pred", AW'(dec_prediction), AW'(exp_pred));
            check("rnd_rec", dec_recovery_target, exp_rec);
            check("rnd_flush", AW'(o_flush), AW'(exp_flush));
            check("rnd_redir", o_redirect_target, exp_redir);
            @(posedge clk);
            model_clock(r, ev, epc, eo);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
